// File: rtl/game_sequencer.sv
// Top-level game flow sequencer: IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> OVER.
// Times the countdown and game-over hold with a ms prescaler; outputs are registered.
module game_sequencer #(
  parameter int unsigned TICKS_PER_MS     = 100000,
  parameter int unsigned STEP_MS          = 333,
  parameter int unsigned COUNT_STEPS      = 3,
  parameter int unsigned GAMEOVER_HOLD_MS = 2000,
  parameter bit          AUTO_RESTART     = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       collision_i,
  output logic [2:0] state_o,
  output logic       run_o,
  output logic       clear_o,
  output logic [1:0] countdown_o,
  output logic       game_over_o
);

  localparam int unsigned CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    OVER      = 3'd4
  } state_t;

  state_t      state;
  logic [CW-1:0] cyc;
  logic [15:0] ms;
  logic        start_q;
  logic        pause_q;

  logic        start_rise;
  logic        pause_rise;
  logic        ms_tick;
  logic [16:0] ms_next;
  logic        step_done;
  logic        hold_done;

  assign start_rise = start_i & ~start_q;
  assign pause_rise = pause_i & ~pause_q;
  assign ms_tick    = (cyc == CW'(TICKS_PER_MS - 1));
  assign ms_next    = {1'b0, ms} + 17'd1;
  // Compare against the incremented ms so the step fires on the wrapping edge,
  // giving exactly N*TICKS_PER_MS cycles from the entry cycle.
  assign step_done  = ms_tick && (ms_next == 17'(STEP_MS));
  assign hold_done  = ms_tick && (ms_next == 17'(GAMEOVER_HOLD_MS));

  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cyc         <= '0;
      ms          <= '0;
      start_q     <= 1'b1;
      pause_q     <= 1'b1;
      run_o       <= 1'b0;
      clear_o     <= 1'b0;
      countdown_o <= '0;
      game_over_o <= 1'b0;
    end else begin
      start_q <= start_i;
      pause_q <= pause_i;
      clear_o <= 1'b0;
      cyc     <= '0;
      ms      <= '0;

      case (state)
        IDLE: begin
          if (start_rise) begin
            state       <= COUNTDOWN;
            clear_o     <= 1'b1;
            countdown_o <= 2'(COUNT_STEPS);
          end
        end

        COUNTDOWN: begin
          if (step_done) begin
            if (countdown_o > 2'd1) begin
              countdown_o <= countdown_o - 2'd1;
            end else begin
              state       <= PLAY;
              countdown_o <= '0;
              run_o       <= 1'b1;
            end
          end else if (ms_tick) begin
            ms <= ms_next[15:0];
          end else begin
            cyc <= cyc + 1'b1;
            ms  <= ms;
          end
        end

        PLAY: begin
          if (collision_i) begin
            state       <= OVER;
            run_o       <= 1'b0;
            game_over_o <= 1'b1;
          end else if (pause_rise) begin
            state <= PAUSE;
            run_o <= 1'b0;
          end
        end

        PAUSE: begin
          if (start_rise) begin
            state <= IDLE;
          end else if (pause_rise) begin
            state <= PLAY;
            run_o <= 1'b1;
          end
        end

        OVER: begin
          if (hold_done) begin
            game_over_o <= 1'b0;
            if (AUTO_RESTART) begin
              state       <= COUNTDOWN;
              clear_o     <= 1'b1;
              countdown_o <= 2'(COUNT_STEPS);
            end else begin
              state <= IDLE;
            end
          end else if (ms_tick) begin
            ms <= ms_next[15:0];
          end else begin
            cyc <= cyc + 1'b1;
            ms  <= ms;
          end
        end

        default: begin
          state       <= IDLE;
          run_o       <= 1'b0;
          countdown_o <= '0;
          game_over_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; second instance exercises AUTO_RESTART=1.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst_ar = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       collision = 1'b0;

  logic [2:0] state, state_ar;
  logic       run, run_ar;
  logic       clear, clear_ar;
  logic [1:0] countdown, countdown_ar;
  logic       game_over, game_over_ar;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICKS_PER_MS(4), .STEP_MS(2), .COUNT_STEPS(3), .GAMEOVER_HOLD_MS(3), .AUTO_RESTART(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause), .collision_i(collision),
    .state_o(state), .run_o(run), .clear_o(clear), .countdown_o(countdown),
    .game_over_o(game_over)
  );

  game_sequencer #(
    .TICKS_PER_MS(4), .STEP_MS(2), .COUNT_STEPS(3), .GAMEOVER_HOLD_MS(3), .AUTO_RESTART(1'b1)
  ) dut_ar (
    .clk_i(clk), .rst_i(rst_ar), .start_i(start), .pause_i(pause), .collision_i(collision),
    .state_o(state_ar), .run_o(run_ar), .clear_o(clear_ar), .countdown_o(countdown_ar),
    .game_over_o(game_over_ar)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic r,
                           input logic c, input logic [1:0] cd, input logic go);
    check({tag, ".state"}, 8'(state), 8'(st));
    check({tag, ".run"}, 8'(run), 8'(r));
    check({tag, ".clear"}, 8'(clear), 8'(c));
    check({tag, ".countdown"}, 8'(countdown), 8'(cd));
    check({tag, ".game_over"}, 8'(game_over), 8'(go));
  endtask

  // Press start and run the full 24-cycle countdown into PLAY.
  task automatic go_to_play(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check_all({tag, ".cd_entry"}, 3'd1, 1'b0, 1'b1, 2'd3, 1'b0);
    repeat (24) step();
    check_all({tag, ".play"}, 3'd2, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    // 1. reset release, idle
    step();
    check_all("reset", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    rst_ar = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle.state", 8'(state), 8'd0);
    end
    check_all("idle_end", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);

    // 2. countdown timing
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("cd.t1", 3'd1, 1'b0, 1'b1, 2'd3, 1'b0);
    step();
    check_all("cd.t2", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0);
    repeat (6) step();
    check("cd.t8", 8'(countdown), 8'd3);
    step();
    check_all("cd.t9", 3'd1, 1'b0, 1'b0, 2'd2, 1'b0);
    repeat (7) step();
    check("cd.t16", 8'(countdown), 8'd2);
    step();
    check_all("cd.t17", 3'd1, 1'b0, 1'b0, 2'd1, 1'b0);
    repeat (7) step();
    check("cd.t24", 8'(state), 8'd1);
    step();
    check_all("cd.t25", 3'd2, 1'b1, 1'b0, 2'd0, 1'b0);
    check("ar.play", 8'(state_ar), 8'd2);

    // 3. collision beats pause; 12-cycle hold; exit per AUTO_RESTART
    collision = 1'b1;
    pause = 1'b1;
    step();
    collision = 1'b0;
    pause = 1'b0;
    check_all("over.entry", 3'd4, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      if (i == 5) start = 1'b1;
      step();
      check("over.hold", 8'(game_over), 8'd1);
    end
    start = 1'b0;
    step();
    check_all("over.exit", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    check("ar.state", 8'(state_ar), 8'd1);
    check("ar.clear", 8'(clear_ar), 8'd1);
    check("ar.countdown", 8'(countdown_ar), 8'd3);
    check("ar.game_over", 8'(game_over_ar), 8'd0);
    rst_ar = 1'b0;

    // 4. pause / resume / abort
    go_to_play("p4");
    pause = 1'b1;
    step();
    pause = 1'b0;
    check_all("pause1", 3'd3, 1'b0, 1'b0, 2'd0, 1'b0);
    collision = 1'b1;
    step();
    collision = 1'b0;
    check("pause.coll", 8'(state), 8'd3);
    pause = 1'b1;
    step();
    pause = 1'b0;
    check_all("resume", 3'd2, 1'b1, 1'b0, 2'd0, 1'b0);
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check_all("pause2", 3'd3, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    start = 1'b1;
    pause = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b0;
    check_all("abort", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);

    // 5. start held through reset release
    start = 1'b1;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    check_all("held", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    start = 1'b0;
    step();
    check("released", 8'(state), 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("repress", 3'd1, 1'b0, 1'b1, 2'd3, 1'b0);

    // 6. async reset mid-countdown, then full countdown
    repeat (3) step();
    check("mid.cd", 8'(state), 8'd1);
    rst = 1'b0;
    #1;
    check("async.state", 8'(state), 8'd0);
    check("async.countdown", 8'(countdown), 8'd0);
    check("async.clear", 8'(clear), 8'd0);
    step();
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("full.t1", 3'd1, 1'b0, 1'b1, 2'd3, 1'b0);
    repeat (23) step();
    check_all("full.t24", 3'd1, 1'b0, 1'b0, 2'd1, 1'b0);
    step();
    check_all("full.t25", 3'd2, 1'b1, 1'b0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
